ahb_slave_regbank: RTL and testbench
====================================

// Module: ahb_slave_regbank
// PURPOSE
//  AHB-Lite responder: word-addressed register bank that completes single NONSEQ/SEQ transfers
//  issued by the AHB master, with programmable wait states and a two-cycle ERROR response.
//  Sits behind the AHB decoder/mux as a memory-mapped peripheral; drives HREADYOUT/HRESP/HRDATA.
// PARAMETERS
//  DATA_WIDTH   32      data bus width (word = DATA_WIDTH bits)
//  ADDR         32      address bus width
//  DEPTH        16      number of DATA_WIDTH registers in the bank
//  WAIT_STATES  1       wait cycles inserted before every OKAY data phase (0..15)
//  BASE_ADDR    'h0     byte address of register 0 (word aligned)
// PORTS
//  i_clk_ahb    in   1           AHB clock, all logic on rising edge
//  i_rstn_ahb   in   1           asynchronous active-low reset
//  i_hsel       in   1           slave select from decoder
//  i_haddr      in   ADDR        byte address (address phase)
//  i_htrans     in   2           00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//  i_hwrite     in   1           1 write, 0 read
//  i_hsize      in   3           transfer size; only 3'b010 (word) supported
//  i_hburst     in   3           ignored (single transfers)
//  i_hprot      in   4           ignored
//  i_hmastlock  in   1           ignored
//  i_hwdata     in   DATA_WIDTH  write data (data phase)
//  i_hready     in   1           bus HREADY (previous transfer complete)
//  o_hreadyout  out  1           0 = extend current data phase
//  o_hresp      out  1           0 OKAY, 1 ERROR
//  o_hrdata     out  DATA_WIDTH  read data (data phase)
// BEHAVIOUR
//  Reset: state IDLE, wait counter 0, captured addr/ctrl 0, all registers 0;
//   o_hreadyout=1, o_hresp=0, o_hrdata=0. Reset mid-transfer aborts it; no write commits.
//  Capture (any state): i_hsel & i_hready & i_htrans[1] -> register idx, write, err flag.
//   idx = (i_haddr-BASE_ADDR)>>2. err = i_hsize!=3'b010 | i_haddr[1:0]!=0
//   | i_haddr<BASE_ADDR | idx>=DEPTH. i_hsel & i_hready with IDLE/BUSY, or i_hsel=0 -> no capture.
//  FSM (next state after capture; without capture in a final cycle -> IDLE):
//   IDLE  : hreadyout=1, hresp=0, hrdata=0. capture: err->ERR1, WAIT_STATES=0->ACCESS, else WAIT.
//   WAIT  : hreadyout=0, hresp=0; counter counts 1..WAIT_STATES; at WAIT_STATES -> ACCESS, cnt<=0.
//   ACCESS: hreadyout=1, hresp=0. write: reg[idx]<=i_hwdata at end of cycle.
//           read: o_hrdata=reg[idx] (combinational from regs), else 0. Capture allowed (pipelined).
//   ERR1  : hreadyout=0, hresp=1, no register update -> ERR2.
//   ERR2  : hreadyout=1, hresp=1; capture allowed (same rules as IDLE).
//  Latency: address phase at cycle N -> data phase completes at cycle N+1+WAIT_STATES.
//  Back-to-back: address phase of next transfer overlaps final cycle of current data phase;
//   with WAIT_STATES=0 sustained one transfer per cycle.
//  Write then read same idx back-to-back returns the new data (write commits before read phase).
//  i_hready low while in IDLE (another slave stalling): no capture, stay IDLE.
//  o_hrdata is 0 in every state other than ACCESS-read; hresp never 1 with OKAY access.
// TESTING
//  Reset: hold i_rstn_ahb=0 -> hreadyout=1, hresp=0, hrdata=0; read every idx after -> 0.
//  WAIT_STATES=1: write 'hDEAD_BEEF to BASE+4, read BASE+4 -> 1 low hreadyout cycle each, hrdata='hDEAD_BEEF.
//  WAIT_STATES=0: writes idx0..3 = 1,2,3,4 back-to-back then reads -> no stalls, data 1,2,3,4 in order.
//  Error: read BASE+4*DEPTH, then write BASE+2, then hsize=3'b000 -> each hreadyout 0/1 with hresp 1,1; regs unchanged.
//  IDLE/BUSY with hsel=1, or NONSEQ with hsel=0 -> hreadyout stays 1, hresp 0, no write.
//  Assert i_rstn_ahb=0 during WAIT of a write to idx2 -> reg[2]=0, FSM IDLE, next transfer OK.

Source files
------------

// File: rtl/ahb_slave_regbank.sv
//==============================================================================
// Module : ahb_slave_regbank
// Desc   : AHB-Lite word register bank with programmable wait states and a
//          two-cycle ERROR response.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module ahb_slave_regbank #(
    parameter int              DATA_WIDTH  = 32,
    parameter int              ADDR        = 32,
    parameter int              DEPTH       = 16,
    parameter int              WAIT_STATES = 1,
    parameter logic [ADDR-1:0] BASE_ADDR   = '0
) (
    input  logic                  i_clk_ahb,
    input  logic                  i_rstn_ahb,
    input  logic                  i_hsel,
    input  logic [ADDR-1:0]       i_haddr,
    input  logic [1:0]            i_htrans,
    input  logic                  i_hwrite,
    input  logic [2:0]            i_hsize,
    input  logic [2:0]            i_hburst,
    input  logic [3:0]            i_hprot,
    input  logic                  i_hmastlock,
    input  logic [DATA_WIDTH-1:0] i_hwdata,
    input  logic                  i_hready,
    output logic                  o_hreadyout,
    output logic                  o_hresp,
    output logic [DATA_WIDTH-1:0] o_hrdata
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_wait   = 3'd1;
    localparam logic [2:0] c_st_access = 3'd2;
    localparam logic [2:0] c_st_err1   = 3'd3;
    localparam logic [2:0] c_st_err2   = 3'd4;

    localparam logic [2:0]      c_size_word = 3'b010;
    localparam logic [ADDR-1:0] c_depth     = ADDR'(DEPTH);
    localparam logic [4:0]      c_wait      = 5'(WAIT_STATES);

    logic [2:0]            r_state;
    logic [2:0]            w_next;
    logic [2:0]            w_launch;
    logic [3:0]            r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_write;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_regs [DEPTH];

    wire            w_capture   = i_hsel & i_hready & i_htrans[1];
    wire [ADDR-1:0] w_offset    = i_haddr - BASE_ADDR;
    wire [ADDR-1:0] w_idx_full  = w_offset >> 2;
    wire            w_err       = (i_hsize != c_size_word) | (i_haddr[1:0] != 2'b00)
                                | (i_haddr < BASE_ADDR) | (w_idx_full >= c_depth);
    wire            w_wait_done = (({1'b0, r_cnt} + 5'd1) == c_wait);
    wire            w_wr_en     = (r_state == c_st_access) & r_write & ~r_err;
    wire            w_unused    = ^{i_htrans[0], i_hburst, i_hprot, i_hmastlock, w_offset[1:0]};

    always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
        if (!i_rstn_ahb) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_launch = c_st_wait;
        if (w_err) begin
            w_launch = c_st_err1;
        end else if (WAIT_STATES == 0) begin
            w_launch = c_st_access;
        end

        w_next = c_st_idle;
        case (r_state)
            c_st_idle, c_st_access, c_st_err2: begin
                if (w_capture) begin
                    w_next = w_launch;
                end
            end
            c_st_wait:  w_next = w_wait_done ? c_st_access : c_st_wait;
            c_st_err1:  w_next = c_st_err2;
            default:    w_next = c_st_idle;
        endcase
    end

    // Read data is only driven during the completing cycle of a read.
    always_comb begin
        o_hreadyout = 1'b1;
        o_hresp     = 1'b0;
        o_hrdata    = '0;
        case (r_state)
            c_st_wait: begin
                o_hreadyout = 1'b0;
            end
            c_st_access: begin
                if (!r_write) begin
                    o_hrdata = r_regs[r_idx];
                end
            end
            c_st_err1: begin
                o_hreadyout = 1'b0;
                o_hresp     = 1'b1;
            end
            c_st_err2: begin
                o_hresp     = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
        if (!i_rstn_ahb) begin
            r_idx   <= '0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_capture) begin
            r_idx   <= w_idx_full[IDX_W-1:0];
            r_write <= i_hwrite;
            r_err   <= w_err;
        end
    end

    always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
        if (!i_rstn_ahb) begin
            r_cnt <= '0;
        end else if (r_state == c_st_wait) begin
            r_cnt <= w_wait_done ? 4'd0 : r_cnt + 4'd1;
        end else begin
            r_cnt <= '0;
        end
    end

    always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
        if (!i_rstn_ahb) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[r_idx] <= i_hwdata;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ahb_slave_regbank.sv
//==============================================================================
// Module : tb_ahb_slave_regbank
// Desc   : Randomized self-checking bench for ahb_slave_regbank; two instances
//          (one wait state at a non-zero base, zero wait states at base 0).
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_ahb_slave_regbank;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE0 = 32'h0000_1000;
    localparam logic [31:0] BASE1 = 32'h0000_0000;
    localparam int          WS0   = 1;
    localparam int          WS1   = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rstn;
    logic [1:0]  hsel;
    logic [1:0]  hwrite;
    logic [1:0]  ovr_low;
    logic [31:0] haddr  [2];
    logic [31:0] hwdata [2];
    logic [1:0]  htrans [2];
    logic [2:0]  hsize  [2];
    logic [2:0]  hburst    = 3'b000;
    logic [3:0]  hprot     = 4'b0011;
    logic        hmastlock = 1'b0;

    wire  [1:0]  hreadyout;
    wire  [1:0]  hresp;
    wire  [1:0]  hready;
    wire  [31:0] hrdata0;
    wire  [31:0] hrdata1;

    // Single-slave bus: HREADY is this slave's HREADYOUT unless another slave is stalling.
    assign hready = hreadyout & ~ovr_low;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] model [2][DEPTH];

    bit          p_wr  [8];
    int          p_idx [8];
    logic [31:0] p_dat [8];
    int          p_n;

    ahb_slave_regbank #(
        .DATA_WIDTH(32), .ADDR(32), .DEPTH(DEPTH), .WAIT_STATES(WS0), .BASE_ADDR(BASE0)
    ) u_dut0 (
        .i_clk_ahb(clk), .i_rstn_ahb(rstn[0]), .i_hsel(hsel[0]), .i_haddr(haddr[0]),
        .i_htrans(htrans[0]), .i_hwrite(hwrite[0]), .i_hsize(hsize[0]), .i_hburst(hburst),
        .i_hprot(hprot), .i_hmastlock(hmastlock), .i_hwdata(hwdata[0]), .i_hready(hready[0]),
        .o_hreadyout(hreadyout[0]), .o_hresp(hresp[0]), .o_hrdata(hrdata0)
    );

    ahb_slave_regbank #(
        .DATA_WIDTH(32), .ADDR(32), .DEPTH(DEPTH), .WAIT_STATES(WS1), .BASE_ADDR(BASE1)
    ) u_dut1 (
        .i_clk_ahb(clk), .i_rstn_ahb(rstn[1]), .i_hsel(hsel[1]), .i_haddr(haddr[1]),
        .i_htrans(htrans[1]), .i_hwrite(hwrite[1]), .i_hsize(hsize[1]), .i_hburst(hburst),
        .i_hprot(hprot), .i_hmastlock(hmastlock), .i_hwdata(hwdata[1]), .i_hready(hready[1]),
        .o_hreadyout(hreadyout[1]), .o_hresp(hresp[1]), .o_hrdata(hrdata1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rdata(input int d);
        return (d == 0) ? hrdata0 : hrdata1;
    endfunction

    function automatic logic [31:0] base_of(input int d);
        return (d == 0) ? BASE0 : BASE1;
    endfunction

    function automatic int ws_of(input int d);
        return (d == 0) ? WS0 : WS1;
    endfunction

    function automatic bit exp_err(input int d, input logic [31:0] a, input logic [2:0] sz);
        logic [31:0] b;
        b = base_of(d);
        if (sz != 3'b010 || a[1:0] != 2'b00 || a < b) return 1'b1;
        return ((a - b) / 4) >= DEPTH;
    endfunction

    task automatic bus_idle(input int d);
        hsel[d]   = 1'b0;
        htrans[d] = 2'b00;
        hwrite[d] = 1'b0;
        haddr[d]  = '0;
        hsize[d]  = 3'b010;
        hwdata[d] = '0;
    endtask

    // One isolated transfer: address phase, then data phase with stall counting.
    task automatic xfer(input int d, input bit wr, input logic [31:0] a,
                        input logic [2:0] sz, input logic [31:0] wd);
        bit err;
        int stalls;
        int idx;
        err = exp_err(d, a, sz);
        idx = err ? 0 : int'((a - base_of(d)) / 4);
        @(negedge clk);
        hsel[d] = 1'b1; haddr[d] = a; htrans[d] = 2'b10; hwrite[d] = wr; hsize[d] = sz;
        @(negedge clk);
        bus_idle(d);
        hwdata[d] = wd;
        stalls = 0;
        while (hreadyout[d] == 1'b0 && stalls < 20) begin
            check_eq("stall_hresp", 32'(hresp[d]), err ? 32'd1 : 32'd0);
            check_eq("stall_rdata", rdata(d), 32'd0);
            stalls++;
            @(negedge clk);
        end
        check_eq("stall_count", 32'(stalls), err ? 32'd1 : 32'(ws_of(d)));
        check_eq("done_hresp", 32'(hresp[d]), 32'(err));
        if (!err && !wr) check_eq("rdata", rdata(d), model[d][idx]);
        else             check_eq("rdata_zero", rdata(d), 32'd0);
        if (!err && wr) model[d][idx] = wd;
    endtask

    task automatic issue(input int d, input int k);
        hsel[d]   = 1'b1;
        haddr[d]  = base_of(d) + 32'(4 * p_idx[k]);
        htrans[d] = (k == 0) ? 2'b10 : 2'b11;
        hwrite[d] = p_wr[k];
        hsize[d]  = 3'b010;
    endtask

    // Pipelined sequence on a zero-wait-state instance: next address overlaps current data.
    task automatic pipe_run(input int d);
        @(negedge clk);
        issue(d, 0);
        for (int k = 0; k < p_n; k++) begin
            @(negedge clk);
            check_eq("b2b_ready", 32'(hreadyout[d]), 32'd1);
            check_eq("b2b_hresp", 32'(hresp[d]), 32'd0);
            if (!p_wr[k]) check_eq("b2b_rdata", rdata(d), model[d][p_idx[k]]);
            else          model[d][p_idx[k]] = p_dat[k];
            if (k + 1 < p_n) issue(d, k + 1);
            else             bus_idle(d);
            hwdata[d] = p_wr[k] ? p_dat[k] : 32'd0;
        end
        @(negedge clk);
        bus_idle(d);
    endtask

    // Patterns that must not start a transfer; a later read proves nothing was written.
    task automatic no_xfer(input int d, input bit sel, input logic [1:0] tr,
                           input bit hold_low, input int idx);
        @(negedge clk);
        ovr_low[d] = hold_low;
        hsel[d] = sel; htrans[d] = tr; hwrite[d] = 1'b1; hsize[d] = 3'b010;
        haddr[d] = base_of(d) + 32'(4 * idx);
        @(negedge clk);
        bus_idle(d);
        ovr_low[d] = 1'b0;
        hwdata[d]  = 32'hBAD0_0000 | 32'(idx);
        check_eq("nox_ready", 32'(hreadyout[d]), 32'd1);
        check_eq("nox_hresp", 32'(hresp[d]), 32'd0);
        repeat (2) @(negedge clk);
        hwdata[d] = '0;
        xfer(d, 1'b0, base_of(d) + 32'(4 * idx), 3'b010, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int          d;
        int          idx;
        int          r;
        bit          wr;
        logic [31:0] a;
        logic [2:0]  sz;

        rstn    = 2'b00;
        ovr_low = 2'b00;
        bus_idle(0);
        bus_idle(1);
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < DEPTH; i++) model[m][i] = '0;

        repeat (3) @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            check_eq("rst_ready", 32'(hreadyout[m]), 32'd1);
            check_eq("rst_hresp", 32'(hresp[m]), 32'd0);
            check_eq("rst_rdata", rdata(m), 32'd0);
        end
        rstn = 2'b11;

        for (int i = 0; i < DEPTH; i++) xfer(0, 1'b0, BASE0 + 32'(4 * i), 3'b010, 32'd0);

        xfer(0, 1'b1, BASE0 + 32'd4, 3'b010, 32'hDEAD_BEEF);
        xfer(0, 1'b0, BASE0 + 32'd4, 3'b010, 32'd0);

        p_n = 8;
        for (int k = 0; k < 4; k++) begin
            p_wr[k]   = 1'b1; p_idx[k]   = k; p_dat[k]   = 32'(k + 1);
            p_wr[k+4] = 1'b0; p_idx[k+4] = k; p_dat[k+4] = 32'd0;
        end
        pipe_run(1);

        p_n = 4;
        p_wr[0] = 1'b1; p_idx[0] = 5; p_dat[0] = $urandom;
        p_wr[1] = 1'b0; p_idx[1] = 5; p_dat[1] = 32'd0;
        p_wr[2] = 1'b1; p_idx[2] = 9; p_dat[2] = $urandom;
        p_wr[3] = 1'b0; p_idx[3] = 9; p_dat[3] = 32'd0;
        pipe_run(1);

        for (int m = 0; m < 2; m++) begin
            xfer(m, 1'b0, base_of(m) + 32'(4 * DEPTH), 3'b010, 32'd0);
            xfer(m, 1'b1, base_of(m) + 32'd2, 3'b010, $urandom);
            xfer(m, 1'b1, base_of(m) + 32'd8, 3'b000, $urandom);
        end
        xfer(0, 1'b0, BASE0 - 32'd4, 3'b010, 32'd0);

        for (int m = 0; m < 2; m++) begin
            no_xfer(m, 1'b1, 2'b00, 1'b0, 3);
            no_xfer(m, 1'b1, 2'b01, 1'b0, 6);
            no_xfer(m, 1'b0, 2'b10, 1'b0, 7);
            no_xfer(m, 1'b1, 2'b10, 1'b1, 8);
        end

        repeat (80) begin
            d   = $urandom_range(0, 1);
            wr  = 1'($urandom_range(0, 1));
            idx = $urandom_range(0, DEPTH + 2);
            a   = base_of(d) + 32'(4 * idx);
            sz  = 3'b010;
            r   = $urandom_range(0, 9);
            if (r == 0) a = a + 32'($urandom_range(1, 3));
            if (r == 1) sz = 3'b001;
            if (r == 2 && d == 0) a = base_of(d) - 32'(4 * $urandom_range(1, 4));
            xfer(d, wr, a, sz, $urandom);
        end

        xfer(0, 1'b1, BASE0 + 32'd8, 3'b010, 32'h1234_5678);
        @(negedge clk);
        hsel[0] = 1'b1; haddr[0] = BASE0 + 32'd8; htrans[0] = 2'b10; hwrite[0] = 1'b1;
        hsize[0] = 3'b010;
        @(negedge clk);
        bus_idle(0);
        hwdata[0] = 32'hCAFE_F00D;
        check_eq("pre_rst_wait", 32'(hreadyout[0]), 32'd0);
        #2 rstn[0] = 1'b0;
        #1;
        check_eq("midrst_ready", 32'(hreadyout[0]), 32'd1);
        check_eq("midrst_hresp", 32'(hresp[0]), 32'd0);
        @(negedge clk);
        rstn[0] = 1'b1;
        for (int i = 0; i < DEPTH; i++) model[0][i] = '0;
        xfer(0, 1'b0, BASE0 + 32'd8, 3'b010, 32'd0);
        xfer(0, 1'b1, BASE0 + 32'd12, 3'b010, 32'h0F0F_A5A5);
        xfer(0, 1'b0, BASE0 + 32'd12, 3'b010, 32'd0);

        for (int m = 0; m < 2; m++)
            for (int i = 0; i < DEPTH; i++) xfer(m, 1'b0, base_of(m) + 32'(4 * i), 3'b010, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
